// File: rtl/cache_ctrl_fsm_if.sv
// Command, response and next-level bus signals of cache_ctrl_fsm.
// slave = controller side, master = front end / memory model side.
interface cache_ctrl_fsm_if #(
  parameter int ADDR_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_inst;
  logic [ADDR_W-1:0] cmd_addr;
  logic              rsp_valid;
  logic              rsp_hit;
  logic              bus_valid;
  logic [1:0]        bus_op;
  logic [ADDR_W-1:0] bus_addr;
  logic [ADDR_W-1:0] bus_wb_addr;
  logic              bus_ack;

  modport slave (
    input  cmd_valid, cmd_inst, cmd_addr, bus_ack,
    output cmd_ready, rsp_valid, rsp_hit,
    output bus_valid, bus_op, bus_addr, bus_wb_addr
  );

  modport master (
    output cmd_valid, cmd_inst, cmd_addr, bus_ack,
    input  cmd_ready, rsp_valid, rsp_hit,
    input  bus_valid, bus_op, bus_addr, bus_wb_addr
  );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// Direct-mapped write-back/write-allocate cache controller FSM.
// Define CACHE_STATS_EN to build the hit/miss statistics counters.
module cache_ctrl_fsm #(
  parameter int ADDR_W      = 32,
  parameter int OFFSET_BITS = 4,
  parameter int SET_BITS    = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  cache_ctrl_fsm_if.slave  ctl,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int NUM_SETS = 1 << SET_BITS;
  localparam int LINE_W   = ADDR_W - OFFSET_BITS;
  localparam int TAG_W    = LINE_W - SET_BITS;

  typedef enum logic [1:0] {
    I_RESET, I_INVAL, I_READ, I_WRITE
  } inst_t;

  typedef enum logic [1:0] {
    READ_OUT, WRITE_OUT, RW_OUT, NOP
  } output_t;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, BUS, CLEAR, RESP
  } state_t;

  state_t              state, state_n;
  inst_t               inst_q;
  logic [LINE_W-1:0]   line_q;
  logic [NUM_SETS-1:0] valid, dirty;
  logic [TAG_W-1:0]    tags [NUM_SETS];
  logic                hit_q;
  logic [SET_BITS-1:0] clr_idx;
  output_t             op_q;
  logic [ADDR_W-1:0]   fill_q, wb_q;

  logic [SET_BITS-1:0] idx;
  logic [TAG_W-1:0]    tag;
  logic                hit, vdirty, rw, inv, accept;
  logic [ADDR_W-1:0]   line_a, victim_a;
  logic                unused_off;

  assign unused_off = ^ctl.cmd_addr[OFFSET_BITS-1:0];

  assign idx      = line_q[SET_BITS-1:0];
  assign tag      = line_q[LINE_W-1:SET_BITS];
  assign hit      = valid[idx] && (tags[idx] == tag);
  assign vdirty   = valid[idx] && dirty[idx];
  assign rw       = (inst_q == I_READ) || (inst_q == I_WRITE);
  assign inv      = (inst_q == I_INVAL);
  assign line_a   = {line_q, {OFFSET_BITS{1'b0}}};
  assign victim_a = {tags[idx], idx, {OFFSET_BITS{1'b0}}};
  assign accept   = (state == IDLE) && ctl.cmd_valid;

  assign ctl.cmd_ready   = (state == IDLE);
  assign ctl.rsp_valid   = (state == RESP);
  assign ctl.rsp_hit     = (state == RESP) && hit_q;
  assign ctl.bus_valid   = (state == BUS);
  assign ctl.bus_op      = (state == BUS) ? op_q : NOP;
  assign ctl.bus_addr    = fill_q;
  assign ctl.bus_wb_addr = wb_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (ctl.cmd_valid)
          state_n = (inst_t'(ctl.cmd_inst) == I_RESET)
                    ? CLEAR : LOOKUP;
      end
      LOOKUP: begin
        unique case (1'b1)
          rw && !hit:          state_n = BUS;
          inv && hit && dirty[idx]:
                               state_n = BUS;
          default:             state_n = RESP;
        endcase
      end
      BUS:   if (ctl.bus_ack) state_n = RESP;
      CLEAR: if (&clr_idx)    state_n = RESP;
      RESP:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_q  <= I_RESET;
      line_q  <= '0;
      valid   <= '0;
      dirty   <= '0;
      hit_q   <= 1'b0;
      clr_idx <= '0;
      op_q    <= NOP;
      fill_q  <= '0;
      wb_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            inst_q  <= inst_t'(ctl.cmd_inst);
            line_q  <= ctl.cmd_addr[ADDR_W-1:OFFSET_BITS];
            hit_q   <= 1'b0;
            clr_idx <= '0;
          end
        end
        LOOKUP: begin
          hit_q <= hit;
          unique case (1'b1)
            rw && hit: begin
              if (inst_q == I_WRITE) dirty[idx] <= 1'b1;
            end
            rw && !hit: begin
              op_q   <= vdirty ? RW_OUT : READ_OUT;
              fill_q <= line_a;
              wb_q   <= vdirty ? victim_a : '0;
            end
            inv && hit && dirty[idx]: begin
              op_q   <= WRITE_OUT;
              fill_q <= '0;
              wb_q   <= line_a;
            end
            inv && hit && !dirty[idx]: begin
              valid[idx] <= 1'b0;
              dirty[idx] <= 1'b0;
            end
            default: ;
          endcase
        end
        BUS: begin
          if (ctl.bus_ack) begin
            valid[idx] <= !inv;
            dirty[idx] <= (inst_q == I_WRITE);
          end
        end
        CLEAR: begin
          valid[clr_idx] <= 1'b0;
          dirty[clr_idx] <= 1'b0;
          clr_idx        <= clr_idx + SET_BITS'(1);
        end
        default: ;
      endcase
    end
  end

  // Tags are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (state == BUS && ctl.bus_ack && !inv)
      tags[idx] <= tag;
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == CLEAR && clr_idx == '0) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP && rw) begin
      if (hit && !(&hit_cnt))
        hit_cnt <= hit_cnt + CNT_W'(1);
      if (!hit && !(&miss_cnt))
        miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif
endmodule
